// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard_if
// Description : Decode/writeback bus of the register file scoreboard.
//               Read ports, two write ports, issue handshake and flush.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if #(
   parameter int WIDTH = 32,
   parameter int ABITS = 5,
   parameter int NREAD = 2
);
   logic [NREAD*ABITS-1:0] RdAddr;
   logic [NREAD*WIDTH-1:0] RdData;
   logic [NREAD-1:0]       RdBusy;
   logic                   WrEnA;
   logic                   WrEnB;
   logic [ABITS-1:0]       WrAddrA;
   logic [ABITS-1:0]       WrAddrB;
   logic [WIDTH-1:0]       WrDataA;
   logic [WIDTH-1:0]       WrDataB;
   logic                   IssueEn;
   logic [ABITS-1:0]       IssueAddr;
   logic                   IssueReady;
   logic                   Flush;
   logic                   Error;

   modport master (
      output RdAddr,
      input  RdData,
      input  RdBusy,
      output WrEnA,
      output WrEnB,
      output WrAddrA,
      output WrAddrB,
      output WrDataA,
      output WrDataB,
      output IssueEn,
      output IssueAddr,
      input  IssueReady,
      output Flush,
      input  Error
   );

   modport slave (
      input  RdAddr,
      output RdData,
      output RdBusy,
      input  WrEnA,
      input  WrEnB,
      input  WrAddrA,
      input  WrAddrB,
      input  WrDataA,
      input  WrDataB,
      input  IssueEn,
      input  IssueAddr,
      output IssueReady,
      input  Flush,
      output Error
   );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Register file with two write ports, NREAD combinational read
//               ports and a per-register pending-write scoreboard. Register 0
//               is hardwired to zero. Optional feature: REGFILE_BYPASS_EN
//               forwards same-cycle writeback data/busy-clear to readers.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
   parameter int WIDTH = 32,
   parameter int ABITS = 5,
   parameter int NREAD = 2
) (
   input  wire logic             Clock,
   input  wire logic             Reset,
   regfile_scoreboard_if.slave   rf_bus
);
   localparam int c_DEPTH = 2**ABITS;

   logic [WIDTH-1:0]       r_data [c_DEPTH];
   logic [c_DEPTH-1:0]     r_busy;
   logic                   r_error;

   logic                   w_wr_a;
   logic                   w_wr_b;
   logic                   w_issue_hit_wr;
   logic                   w_issue_ready;
   logic                   w_issue_acc;
   logic [c_DEPTH-1:0]     w_busy_nxt;
   logic [NREAD*WIDTH-1:0] w_rd_data;
   logic [NREAD-1:0]       w_rd_busy;

   assign w_wr_a = rf_bus.WrEnA && (rf_bus.WrAddrA != '0);
   assign w_wr_b = rf_bus.WrEnB && (rf_bus.WrAddrB != '0);

   // A writeback landing this cycle frees the register in time for a reissue
   assign w_issue_hit_wr = (rf_bus.WrEnA && (rf_bus.WrAddrA == rf_bus.IssueAddr)) ||
                           (rf_bus.WrEnB && (rf_bus.WrAddrB == rf_bus.IssueAddr));
   assign w_issue_ready  = (rf_bus.IssueAddr == '0) || !r_busy[rf_bus.IssueAddr] ||
                           w_issue_hit_wr;
   assign w_issue_acc    = rf_bus.IssueEn && w_issue_ready && (rf_bus.IssueAddr != '0);

   // Priority, lowest to highest: write clear, issue set, flush
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_a) begin
         w_busy_nxt[rf_bus.WrAddrA] = 1'b0;
      end
      if (w_wr_b) begin
         w_busy_nxt[rf_bus.WrAddrB] = 1'b0;
      end
      if (w_issue_acc) begin
         w_busy_nxt[rf_bus.IssueAddr] = 1'b1;
      end
      if (rf_bus.Flush) begin
         w_busy_nxt = '0;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_busy  <= '0;
         r_error <= 1'b0;
         for (int j = 0; j < c_DEPTH; j++) begin
            r_data[j] <= '0;
         end
      end else begin
         r_busy <= w_busy_nxt;
         if (rf_bus.IssueEn && !w_issue_ready) begin
            r_error <= 1'b1;
         end
         if (w_wr_a) begin
            r_data[rf_bus.WrAddrA] <= rf_bus.WrDataA;
         end
         // Port B is applied last so it wins a same-address collision
         if (w_wr_b) begin
            r_data[rf_bus.WrAddrB] <= rf_bus.WrDataB;
         end
      end
   end

   for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [ABITS-1:0] w_addr;
      logic [WIDTH-1:0] w_stored;
      logic             w_stored_busy;

      assign w_addr        = rf_bus.RdAddr[gi*ABITS +: ABITS];
      assign w_stored      = (w_addr == '0) ? '0 : r_data[w_addr];
      assign w_stored_busy = (w_addr != '0) && r_busy[w_addr];

`ifdef REGFILE_BYPASS_EN
      logic w_hit_a;
      logic w_hit_b;
      logic w_keep_busy;

      assign w_hit_a     = w_wr_a && (rf_bus.WrAddrA == w_addr);
      assign w_hit_b     = w_wr_b && (rf_bus.WrAddrB == w_addr);
      // A same-cycle accepted reissue keeps the stored busy view
      assign w_keep_busy = w_issue_acc && (rf_bus.IssueAddr == w_addr);

      assign w_rd_data[gi*WIDTH +: WIDTH] = w_hit_b ? rf_bus.WrDataB :
                                            w_hit_a ? rf_bus.WrDataA : w_stored;
      assign w_rd_busy[gi] = w_stored_busy && !((w_hit_a || w_hit_b) && !w_keep_busy);
`else
      assign w_rd_data[gi*WIDTH +: WIDTH] = w_stored;
      assign w_rd_busy[gi]                = w_stored_busy;
`endif
   end

   assign rf_bus.RdData     = w_rd_data;
   assign rf_bus.RdBusy     = w_rd_busy;
   assign rf_bus.IssueReady = w_issue_ready;
   assign rf_bus.Error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench for regfile_scoreboard using a queue of
//               expected read/handshake values checked at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
   localparam int c_WIDTH = 32;
   localparam int c_ABITS = 5;
   localparam int c_NREAD = 2;

   localparam int c_K_DATA  = 0;
   localparam int c_K_BUSY  = 1;
   localparam int c_K_READY = 2;
   localparam int c_K_ERROR = 3;

   typedef struct {
      string       tag;
      int          kind;
      int          port;
      logic [31:0] exp;
   } sb_item_t;

   logic     Clock;
   logic     Reset;
   sb_item_t r_sb_q[$];
   int       n_tests;
   int       n_fail;

   regfile_scoreboard_if #(.WIDTH(c_WIDTH), .ABITS(c_ABITS), .NREAD(c_NREAD)) rf ();

   regfile_scoreboard #(
      .WIDTH (c_WIDTH),
      .ABITS (c_ABITS),
      .NREAD (c_NREAD)
   ) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .rf_bus (rf.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rf.WrEnA     = 1'b0;
      rf.WrEnB     = 1'b0;
      rf.WrAddrA   = '0;
      rf.WrAddrB   = '0;
      rf.WrDataA   = '0;
      rf.WrDataB   = '0;
      rf.IssueEn   = 1'b0;
      rf.IssueAddr = '0;
      rf.Flush     = 1'b0;
      rf.RdAddr    = '0;
   endtask

   task automatic expect_rd(input string tag, input int port, input logic [4:0] addr,
                            input logic [31:0] d, input logic b);
      sb_item_t it;
      rf.RdAddr[port*c_ABITS +: c_ABITS] = addr;
      it.tag = {tag, "_data"}; it.kind = c_K_DATA; it.port = port; it.exp = d;
      r_sb_q.push_back(it);
      it.tag = {tag, "_busy"}; it.kind = c_K_BUSY; it.exp = {31'd0, b};
      r_sb_q.push_back(it);
   endtask

   task automatic expect_sig(input string tag, input int kind, input logic v);
      sb_item_t it;
      it.tag = tag; it.kind = kind; it.port = 0; it.exp = {31'd0, v};
      r_sb_q.push_back(it);
   endtask

   // Inputs are driven 1 time unit after a rising edge; outputs compared at the falling edge
   task automatic step();
      sb_item_t    it;
      logic [31:0] obs;
      #4;
      while (r_sb_q.size() > 0) begin
         it = r_sb_q.pop_front();
         case (it.kind)
            c_K_DATA:  obs = rf.RdData[it.port*c_WIDTH +: c_WIDTH];
            c_K_BUSY:  obs = {31'd0, rf.RdBusy[it.port]};
            c_K_READY: obs = {31'd0, rf.IssueReady};
            default:   obs = {31'd0, rf.Error};
         endcase
         check_val(it.tag, {32'd0, obs}, {32'd0, it.exp});
      end
      @(posedge Clock);
      #1;
      idle();
   endtask

   task automatic check_all_clear(input string tag);
      for (int a = 0; a < 32; a++) begin
         expect_rd($sformatf("%s_p0_a%0d", tag, a), 0, 5'(a), 32'd0, 1'b0);
         expect_rd($sformatf("%s_p1_a%0d", tag, a), 1, 5'(31 - a), 32'd0, 1'b0);
         rf.IssueAddr = 5'(a);
         expect_sig($sformatf("%s_ready_a%0d", tag, a), c_K_READY, 1'b1);
         expect_sig($sformatf("%s_err_a%0d", tag, a), c_K_ERROR, 1'b0);
         step();
      end
   endtask

   initial begin
      logic [31:0] exp_same;
      n_tests = 0;
      n_fail  = 0;
      idle();
      Reset = 1'b1;
      @(posedge Clock);
      @(posedge Clock);
      #1;
      // Reset values are visible while Reset is still high
      expect_rd("rst_hold", 0, 5'd5, 32'd0, 1'b0);
      expect_sig("rst_hold_ready", c_K_READY, 1'b1);
      expect_sig("rst_hold_err", c_K_ERROR, 1'b0);
      step();
      Reset = 1'b0;
      check_all_clear("reset");

      // Dual write to one address: port B wins
      rf.WrEnA = 1'b1; rf.WrAddrA = 5'd5; rf.WrDataA = 32'hDEADBEEF;
      rf.WrEnB = 1'b1; rf.WrAddrB = 5'd5; rf.WrDataB = 32'h12345678;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'h12345678;
`else
      exp_same = 32'h0;
`endif
      expect_rd("wr5_same", 0, 5'd5, exp_same, 1'b0);
      step();
      expect_rd("wr5_after", 0, 5'd5, 32'h12345678, 1'b0);
      step();
      rf.WrEnA = 1'b1; rf.WrAddrA = 5'd0; rf.WrDataA = 32'hFFFFFFFF;
      rf.WrEnB = 1'b1; rf.WrAddrB = 5'd0; rf.WrDataB = 32'hFFFFFFFF;
      expect_rd("wr0_same", 0, 5'd0, 32'd0, 1'b0);
      step();
      expect_rd("wr0_after", 0, 5'd0, 32'd0, 1'b0);
      expect_rd("wr0_keep5", 1, 5'd5, 32'h12345678, 1'b0);
      step();

      // Issue handshake and sticky error
      rf.IssueEn = 1'b1; rf.IssueAddr = 5'd7;
      expect_sig("iss7_ready", c_K_READY, 1'b1);
      expect_rd("iss7_pre", 0, 5'd7, 32'd0, 1'b0);
      step();
      rf.IssueAddr = 5'd7;
      expect_rd("iss7_busy", 0, 5'd7, 32'd0, 1'b1);
      expect_sig("iss7_notready", c_K_READY, 1'b0);
      expect_sig("iss7_err0", c_K_ERROR, 1'b0);
      step();
      rf.IssueEn = 1'b1; rf.IssueAddr = 5'd7;
      expect_sig("iss7_again_notready", c_K_READY, 1'b0);
      step();
      rf.IssueAddr = 5'd7;
      rf.WrEnA = 1'b1; rf.WrAddrA = 5'd7; rf.WrDataA = 32'h00000077;
`ifdef REGFILE_BYPASS_EN
      expect_rd("wb7_same", 0, 5'd7, 32'h00000077, 1'b0);
`else
      expect_rd("wb7_same", 0, 5'd7, 32'd0, 1'b1);
`endif
      expect_sig("wb7_ready", c_K_READY, 1'b1);
      expect_sig("iss7_err1", c_K_ERROR, 1'b1);
      step();
      rf.IssueAddr = 5'd7;
      expect_rd("wb7_after", 0, 5'd7, 32'h00000077, 1'b0);
      expect_sig("wb7_after_ready", c_K_READY, 1'b1);
      expect_sig("err_sticky", c_K_ERROR, 1'b1);
      step();

      // Same-cycle writeback and reissue: set wins
      rf.IssueEn = 1'b1; rf.IssueAddr = 5'd9;
      step();
      rf.IssueEn = 1'b1; rf.IssueAddr = 5'd12;
      step();
      rf.IssueEn = 1'b1; rf.IssueAddr = 5'd9;
      rf.WrEnB = 1'b1; rf.WrAddrB = 5'd9; rf.WrDataB = 32'h00000099;
      expect_sig("reiss9_ready", c_K_READY, 1'b1);
      expect_rd("reiss9_same", 0, 5'd9, exp_same == 32'd0 ? 32'd0 : 32'h00000099, 1'b1);
      step();
      rf.IssueAddr = 5'd9;
      expect_rd("reiss9_busy", 0, 5'd9, 32'h00000099, 1'b1);
      expect_rd("iss12_busy", 1, 5'd12, 32'd0, 1'b1);
      expect_sig("reiss9_notready", c_K_READY, 1'b0);
      step();

      // Flush beats a coincident issue and keeps data
      rf.Flush = 1'b1; rf.IssueEn = 1'b1; rf.IssueAddr = 5'd3;
      step();
      expect_rd("flush_3", 0, 5'd3, 32'd0, 1'b0);
      expect_rd("flush_9", 1, 5'd9, 32'h00000099, 1'b0);
      rf.IssueAddr = 5'd12;
      expect_sig("flush_ready12", c_K_READY, 1'b1);
      expect_sig("flush_err", c_K_ERROR, 1'b1);
      step();
      expect_rd("flush_12", 0, 5'd12, 32'd0, 1'b0);
      expect_rd("flush_7", 1, 5'd7, 32'h00000077, 1'b0);
      step();

      // Write-to-read latency
      rf.WrEnA = 1'b1; rf.WrAddrA = 5'd4; rf.WrDataA = 32'hA5A5A5A5;
      expect_rd("wr4_same", 1, 5'd4, exp_same == 32'd0 ? 32'd0 : 32'hA5A5A5A5, 1'b0);
      step();
      expect_rd("wr4_after", 1, 5'd4, 32'hA5A5A5A5, 1'b0);
      step();

      // Load more state, then reset with activity in flight
      rf.IssueEn = 1'b1; rf.IssueAddr = 5'd10;
      rf.WrEnA = 1'b1; rf.WrAddrA = 5'd11; rf.WrDataA = 32'h00001111;
      step();
      expect_rd("pre_rst_10", 0, 5'd10, 32'd0, 1'b1);
      expect_rd("pre_rst_11", 1, 5'd11, 32'h00001111, 1'b0);
      step();
      Reset = 1'b1;
      rf.WrEnB = 1'b1; rf.WrAddrB = 5'd12; rf.WrDataB = 32'h0000CCCC;
      rf.IssueEn = 1'b1; rf.IssueAddr = 5'd13;
      step();
      Reset = 1'b0;
      check_all_clear("post_rst");

      check_val("sb_drain", 64'(r_sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the pipelined core: configurable width, depth and read-port count, two synchronous write ports, and a per-register scoreboard of pending writes. It sits between decode (reads and issues) and writeback (writes), and gives decode the operand data plus a busy flag for hazard stalling. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- ABITS, 5, address width; depth is 2**ABITS registers
- NREAD, 2, number of asynchronous read ports

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- RdAddr  in  NREAD*ABITS  read addresses; port i uses bits [i*ABITS +: ABITS]
- RdData  out  NREAD*WIDTH  read data; port i uses bits [i*WIDTH +: WIDTH]
- RdBusy  out  NREAD  port i: addressed register has a pending write
- WrEnA, WrEnB  in  1  write enables; B is the higher-priority port
- WrAddrA, WrAddrB  in  ABITS  write addresses
- WrDataA, WrDataB  in  WIDTH  write data
- IssueEn  in  1  request to mark IssueAddr as pending
- IssueAddr  in  ABITS  destination register of the instruction being issued
- IssueReady  out  1  IssueAddr may be marked this cycle
- Flush  in  1  clear all pending marks (pipeline flush)
- Error  out  1  sticky: issue attempted while not ready

## Operation
- Storage: 2**ABITS x WIDTH data array and a 2**ABITS-bit busy vector. Entry 0's data and busy bit are constant 0.
- Reads are combinational. RdData[i] = data[RdAddr[i]] and RdBusy[i] = busy[RdAddr[i]]. Address 0 always reads 0 / not busy.
- Writes:
  - WrEnX with WrAddrX != 0 writes data at the edge and clears busy[WrAddrX].
  - If both ports hit the same address, port B's data wins; busy is cleared once.
  - Writes to address 0 are ignored.
- Issue handshake:
  - IssueReady = (IssueAddr == 0) | ~busy[IssueAddr] | (the same address is written this cycle on A or B).
  - IssueEn & IssueReady with IssueAddr != 0 sets busy[IssueAddr] at the edge.
  - IssueEn & ~IssueReady changes no busy bit and sets Error. Error clears only on Reset.
- Same-cycle write-clear and issue-set on one address: the set wins, and busy ends at 1.
- Flush clears every busy bit at the edge and leaves data untouched. When Flush coincides with an issue, Flush wins and busy ends at 0; Error is still evaluated.
- Reset clears all data to 0, all busy bits to 0, and Error to 0. Reset overrides every other input.

## Timing
- Read latency is 0 cycles (combinational from RdAddr and state).
- Write-to-read latency is 1 edge without bypass. With bypass it is 0, as described under Configuration.
- Issue-to-busy: RdBusy is visible 1 edge after the accepted IssueEn.
- Writeback-to-not-busy: 1 edge, or 0 with bypass.
- Reset values while Reset is high and after the first edge: RdData = 0, RdBusy = 0, IssueReady = 1, Error = 0.
- Reset asserted mid-operation discards pending marks and in-flight writes on that edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Each read port forwards the same-cycle write data when WrEnX and WrAddrX match RdAddr[i] (and are nonzero), with B over A.
  - RdBusy[i] reads 0 for that address in that cycle unless an IssueEn for it is accepted in the same cycle; issue changes busy only from the next edge.
- REGFILE_BYPASS_EN undefined:
  - Reads return stored array contents only.
  - RdBusy reflects the registered busy vector.
  - A write becomes visible the cycle after its edge.

## Test plan
- Reset, then read all addresses on every port -> RdData = 0, RdBusy = 0, IssueReady = 1, Error = 0.
- Write A addr 5 = 0xDEADBEEF and B addr 5 = 0x12345678 in the same cycle, then read addr 5 -> 0x12345678. Write addr 0 = 0xFFFFFFFF -> addr 0 still reads 0.
- Issue addr 7, next cycle RdBusy = 1 and IssueReady low for addr 7. Issue addr 7 again -> Error = 1, busy unchanged. Write addr 7 -> busy 0 the next cycle; Error stays 1 until Reset.
- Same cycle: write addr 9 plus issue addr 9 while busy[9] = 1 -> IssueReady = 1 and busy[9] = 1 afterwards. Then Flush together with an issue of addr 3 -> all busy = 0.
- With REGFILE_BYPASS_EN: write addr 4 = 0xA5A5A5A5 while reading addr 4 -> RdData = 0xA5A5A5A5 in the same cycle. Without the macro -> old value that cycle and the new value the next.
- Assert Reset for one cycle after loading several registers and busy bits -> all data 0, all busy 0, Error 0 on the following cycle.
